// File: rtl/rf_pkg.sv
// Shared types and defaults for the scoreboarded register file.
package rf_pkg;
    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int unsigned ZERO_REG = 0;

    typedef logic [RF_ADDR_WIDTH-1:0] reg_idx_t;
endpackage

// File: rtl/scoreboard_register_file_if.sv
// Read, writeback and reservation bundle of the register file.
interface scoreboard_register_file_if
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] Read_Reg_1;
    logic [ADDR_WIDTH-1:0] Read_Reg_2;
    logic [DATA_WIDTH-1:0] Read_Data_1;
    logic [DATA_WIDTH-1:0] Read_Data_2;
    logic                  Read_Ready_1;
    logic                  Read_Ready_2;
    logic                  Register_Write;
    logic [ADDR_WIDTH-1:0] Write_Reg;
    logic [DATA_WIDTH-1:0] Register_Write_Data;
    logic                  Reserve_En;
    logic [ADDR_WIDTH-1:0] Reserve_Reg;
    logic                  Reserve_Stall;
    logic [ADDR_WIDTH:0]   Busy_Count;

    modport master (
        output Read_Reg_1, Read_Reg_2,
        output Register_Write, Write_Reg, Register_Write_Data,
        output Reserve_En, Reserve_Reg,
        input  Read_Data_1, Read_Data_2,
        input  Read_Ready_1, Read_Ready_2,
        input  Reserve_Stall, Busy_Count
    );

    modport slave (
        input  Read_Reg_1, Read_Reg_2,
        input  Register_Write, Write_Reg, Register_Write_Data,
        input  Reserve_En, Reserve_Reg,
        output Read_Data_1, Read_Data_2,
        output Read_Ready_1, Read_Ready_2,
        output Reserve_Stall, Busy_Count
    );
endinterface

// File: rtl/busy_scoreboard.sv
// Pending-producer bits, WAW reservation stall and registered busy count.
module busy_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_reg_i,
    input  logic                  reserve_en_i,
    input  logic [ADDR_WIDTH-1:0] reserve_reg_i,
    input  logic [ADDR_WIDTH-1:0] rd_reg_1_i,
    input  logic [ADDR_WIDTH-1:0] rd_reg_2_i,
    output logic                  busy_1_o,
    output logic                  busy_2_o,
    output logic                  stall_o,
    output logic [ADDR_WIDTH:0]   count_o
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(ZERO_REG);
    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                wr_ok, set, inc, dec;

    always_comb begin
        wr_ok   = wr_en_i && (wr_reg_i != ZERO);
        stall_o = reserve_en_i && (reserve_reg_i != ZERO)
                  && busy_q[reserve_reg_i]
                  && !(wr_en_i && (wr_reg_i == reserve_reg_i));
        set     = reserve_en_i && (reserve_reg_i != ZERO) && !stall_o;
        // Count moves only when a bit really flips; set beats clear.
        inc     = set && !busy_q[reserve_reg_i];
        dec     = wr_ok && busy_q[wr_reg_i]
                  && !(set && (reserve_reg_i == wr_reg_i));

        busy_d = busy_q;
        if (wr_ok) busy_d[wr_reg_i] = 1'b0;
        if (set)   busy_d[reserve_reg_i] = 1'b1;

        count_d = count_q;
        if (inc && !dec)      count_d = count_q + ONE;
        else if (dec && !inc) count_d = count_q - ONE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_1_o = busy_q[rd_reg_1_i];
    assign busy_2_o = busy_q[rd_reg_2_i];
    assign count_o  = count_q;
endmodule

// File: rtl/scoreboard_register_file.sv
// Two-read, one-write register file with write-through bypass and scoreboard.
module scoreboard_register_file
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic Clk,
    input  logic Reset,
    scoreboard_register_file_if.slave bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic                  wr_ok, hit_1, hit_2, busy_1, busy_2;

    assign wr_ok = bus.Register_Write && (bus.Write_Reg != ZERO);
    assign hit_1 = wr_ok && (bus.Write_Reg == bus.Read_Reg_1);
    assign hit_2 = wr_ok && (bus.Write_Reg == bus.Read_Reg_2);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_ok) begin
            regs_q[bus.Write_Reg] <= bus.Register_Write_Data;
        end
    end

    assign bus.Read_Data_1  = hit_1 ? bus.Register_Write_Data
                                    : regs_q[bus.Read_Reg_1];
    assign bus.Read_Data_2  = hit_2 ? bus.Register_Write_Data
                                    : regs_q[bus.Read_Reg_2];
    assign bus.Read_Ready_1 = !busy_1 || hit_1;
    assign bus.Read_Ready_2 = !busy_2 || hit_2;

    busy_scoreboard #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_busy (
        .clk_i        (Clk),
        .rst_i        (Reset),
        .wr_en_i      (bus.Register_Write),
        .wr_reg_i     (bus.Write_Reg),
        .reserve_en_i (bus.Reserve_En),
        .reserve_reg_i(bus.Reserve_Reg),
        .rd_reg_1_i   (bus.Read_Reg_1),
        .rd_reg_2_i   (bus.Read_Reg_2),
        .busy_1_o     (busy_1),
        .busy_2_o     (busy_2),
        .stall_o      (bus.Reserve_Stall),
        .count_o      (bus.Busy_Count)
    );
endmodule
